// File: rtl/cache_refill_ctrl_pkg.sv
// Shared cache types: refill FSM states, address split and block-base helper.
package cache_refill_ctrl_pkg;

  localparam int DEF_RAM_ADDRESS_BITS = 10;
  localparam int DEF_DATA_BITS        = 32;
  localparam int DEF_BLOCK_BITS       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } refill_state_t;

  // Word address split into block number and word offset, shared with the cache.
  typedef struct packed {
    logic [DEF_RAM_ADDRESS_BITS-DEF_BLOCK_BITS-1:0] block;
    logic [DEF_BLOCK_BITS-1:0]                      offset;
  } addr_split_t;

  // Clears the word-offset bits so the address points at word 0 of its block.
  function automatic logic [31:0] block_base(input logic [31:0] addr,
                                             input int unsigned block_bits);
    return addr & ~((32'd1 << block_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Single-word RAM port: request/ack handshake with write data and read data.
interface cache_refill_ctrl_if #(
  parameter int RAM_ADDRESS_BITS = 10,
  parameter int DATA_BITS        = 32
);
  logic                        mem_req;
  logic                        mem_we;
  logic [RAM_ADDRESS_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0]        mem_wdata;
  logic                        mem_ack;
  logic [DATA_BITS-1:0]        mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss sequencer: optional word-by-word victim write-back, then block refill.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int  RAM_ADDRESS_BITS = DEF_RAM_ADDRESS_BITS,
  parameter int  DATA_BITS        = DEF_DATA_BITS,
  parameter int  BLOCK_BITS       = DEF_BLOCK_BITS,
  localparam int BLOCK_SIZE       = 1 << BLOCK_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  miss_req,
  input  logic [RAM_ADDRESS_BITS-1:0]           miss_addr,
  input  logic                                  wb_en,
  input  logic [RAM_ADDRESS_BITS-1:0]           wb_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_BITS-1:0]  wb_data,
  output logic                                  fill_valid,
  output logic [BLOCK_SIZE-1:0][DATA_BITS-1:0]  fill_data,
  output logic                                  busy,
  cache_refill_ctrl_if.master                   mem
);

  localparam logic [BLOCK_BITS-1:0] LAST_WORD = BLOCK_BITS'(BLOCK_SIZE - 1);

  refill_state_t                         state_r;
  refill_state_t                         next_state_s;
  logic [BLOCK_BITS-1:0]                 cnt_r;
  logic [RAM_ADDRESS_BITS-1:0]           fill_base_r;
  logic [RAM_ADDRESS_BITS-1:0]           wb_base_r;
  logic [BLOCK_SIZE-1:0][DATA_BITS-1:0]  wb_buf_r;
  logic [BLOCK_SIZE-1:0][DATA_BITS-1:0]  fill_buf_r;
  logic [BLOCK_SIZE-1:0][DATA_BITS-1:0]  fill_data_r;
  logic [RAM_ADDRESS_BITS-1:0]           cnt_ext_s;
  logic                                  last_word_s;

  assign last_word_s = (cnt_r == LAST_WORD);
  assign cnt_ext_s   = {{(RAM_ADDRESS_BITS-BLOCK_BITS){1'b0}}, cnt_r};

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; the ack only advances the FSM in the bus-owning states.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (miss_req) begin
          next_state_s = wb_en ? WB : FILL;
        end else begin
          next_state_s = IDLE;
        end
      end
      WB: begin
        if (mem.mem_ack && last_word_s) begin
          next_state_s = FILL;
        end else begin
          next_state_s = WB;
        end
      end
      FILL: begin
        if (mem.mem_ack && last_word_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = FILL;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request capture, word counter and block buffers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r       <= '0;
      fill_base_r <= '0;
      wb_base_r   <= '0;
      wb_buf_r    <= '0;
      fill_buf_r  <= '0;
      fill_data_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_req) begin
            fill_base_r <= RAM_ADDRESS_BITS'(block_base(32'(miss_addr), BLOCK_BITS));
            wb_base_r   <= RAM_ADDRESS_BITS'(block_base(32'(wb_addr), BLOCK_BITS));
            wb_buf_r    <= wb_data;
            cnt_r       <= '0;
          end
        end
        WB: begin
          if (mem.mem_ack) begin
            cnt_r <= cnt_r + BLOCK_BITS'(1);
          end
        end
        FILL: begin
          if (mem.mem_ack) begin
            fill_buf_r[cnt_r] <= mem.mem_rdata;
            cnt_r             <= cnt_r + BLOCK_BITS'(1);
            // Publish the whole block as DONE begins; the final word comes straight off the bus.
            if (last_word_s) begin
              fill_data_r                 <= fill_buf_r;
              fill_data_r[BLOCK_SIZE-1]   <= mem.mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // RAM port decoded from state and registered fields only, never from miss_req.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (state_r == WB) begin
      mem.mem_req   = 1'b1;
      mem.mem_we    = 1'b1;
      mem.mem_addr  = wb_base_r | cnt_ext_s;
      mem.mem_wdata = wb_buf_r[cnt_r];
    end else if (state_r == FILL) begin
      mem.mem_req   = 1'b1;
      mem.mem_addr  = fill_base_r | cnt_ext_s;
    end else begin
      mem.mem_req   = 1'b0;
    end
  end

  assign busy       = (state_r != IDLE);
  assign fill_valid = (state_r == DONE);
  assign fill_data  = fill_data_r;

endmodule
